// File: rtl/pe_pkg.sv
// Shared constants and configuration type for the weight-stationary multi-bank PE.
package pe_pkg;

    localparam int DEF_ARRAY_WIDTH = 16;
    localparam int DEF_DIN_W       = 8;
    localparam int DEF_ACC_W       = 32;
    localparam int DEF_NUM_BANKS   = 4;
    localparam int DEF_SATURATE    = 0;

    typedef struct packed {
        int   din_w;
        int   acc_w;
        int   num_banks;
        logic saturate;
    } pe_cfg_t;

endpackage

// File: rtl/pe_weight_bank.sv
// Banked weight storage with an active-bank pointer; reads are combinational from
// the registered banks, so a same-cycle write is seen only from the next cycle.
module pe_weight_bank
    import pe_pkg::*;
#(
    parameter int DIN_W     = DEF_DIN_W,
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    localparam int BANK_W   = $clog2(NUM_BANKS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enabled,
    input  logic                    wr_en,
    input  logic [BANK_W-1:0]       wr_bank,
    input  logic signed [DIN_W-1:0] wr_data,
    input  logic                    sw_en,
    input  logic [BANK_W-1:0]       sw_bank,
    output logic [BANK_W-1:0]       active_bank,
    output logic signed [DIN_W-1:0] active_weight
);

    logic signed [DIN_W-1:0] bank [NUM_BANKS];

    // A disabled column forgets its weights and falls back to bank 0.
    always_ff @(posedge clk) begin
        if (rst || !enabled) begin
            for (int i = 0; i < NUM_BANKS; i++) bank[i] <= '0;
            active_bank <= '0;
        end else begin
            if (wr_en) bank[wr_bank] <= wr_data;
            if (sw_en) active_bank <= sw_bank;
        end
    end

    assign active_weight = bank[active_bank];

endmodule

// File: rtl/pe_mb.sv
// Systolic PE: west->east activations, north->south weight load path and psum chain,
// MAC against the active weight bank with optional saturation and a sticky overflow flag.
module pe_mb
    import pe_pkg::*;
#(
    parameter int ROW_ID      = 0,
    parameter int ARRAY_WIDTH = DEF_ARRAY_WIDTH,
    parameter int DIN_W       = DEF_DIN_W,
    parameter int ACC_W       = DEF_ACC_W,
    parameter int NUM_BANKS   = DEF_NUM_BANKS,
    parameter int SATURATE    = DEF_SATURATE,
    localparam int IDX_W      = $clog2(ARRAY_WIDTH),
    localparam int BANK_W     = $clog2(NUM_BANKS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enabled,
    input  logic                    clear_ovf,
    // west
    input  logic                    valid_in,
    input  logic                    switch_in,
    input  logic [BANK_W-1:0]       switch_bank_in,
    input  logic signed [DIN_W-1:0] act_in,
    // north
    input  logic                    accept_w_in,
    input  logic signed [DIN_W-1:0] weight_in,
    input  logic [IDX_W-1:0]        index_in,
    input  logic [BANK_W-1:0]       bank_in,
    input  logic signed [ACC_W-1:0] psum_in,
    input  logic                    psum_valid_in,
    // east
    output logic signed [DIN_W-1:0] act_out,
    output logic                    valid_out,
    output logic                    switch_out,
    output logic [BANK_W-1:0]       switch_bank_out,
    // south
    output logic signed [DIN_W-1:0] weight_out,
    output logic [IDX_W-1:0]        index_out,
    output logic [BANK_W-1:0]       bank_out,
    output logic                    accept_w_out,
    output logic signed [ACC_W-1:0] psum_out,
    output logic                    psum_valid_out,
    // status
    output logic [BANK_W-1:0]       active_bank,
    output logic                    ovf
);

    localparam int PROD_W = 2 * DIN_W;

    logic                    match;
    logic                    fwd;
    logic signed [DIN_W-1:0] w_act;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W:0]   mac;
    logic                    ovf_now;
    logic signed [ACC_W-1:0] res;

    assign match = accept_w_in && (index_in == IDX_W'(ROW_ID));
    assign fwd   = accept_w_in && !match;

    pe_weight_bank #(
        .DIN_W     (DIN_W),
        .NUM_BANKS (NUM_BANKS)
    ) u_bank (
        .clk           (clk),
        .rst           (rst),
        .enabled       (enabled),
        .wr_en         (match),
        .wr_bank       (bank_in),
        .wr_data       (weight_in),
        .sw_en         (switch_in),
        .sw_bank       (switch_bank_in),
        .active_bank   (active_bank),
        .active_weight (w_act)
    );

    // One guard bit above ACC_W: overflow shows up as the top two bits disagreeing.
    assign prod    = act_in * w_act;
    assign mac     = {{(ACC_W+1-PROD_W){prod[PROD_W-1]}}, prod} + {psum_in[ACC_W-1], psum_in};
    assign ovf_now = mac[ACC_W] ^ mac[ACC_W-1];

    always_comb begin
        res = mac[ACC_W-1:0];
        if (SATURATE != 0 && ovf_now)
            res = mac[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_out         <= '0;
            valid_out       <= 1'b0;
            switch_out      <= 1'b0;
            switch_bank_out <= '0;
            weight_out      <= '0;
            index_out       <= '0;
            bank_out        <= '0;
            accept_w_out    <= 1'b0;
            psum_out        <= '0;
            psum_valid_out  <= 1'b0;
            ovf             <= 1'b0;
        end else if (!enabled) begin
            // bypassed column: psum chain passes straight through, ovf frozen
            act_out         <= '0;
            valid_out       <= 1'b0;
            switch_out      <= 1'b0;
            switch_bank_out <= '0;
            weight_out      <= '0;
            index_out       <= '0;
            bank_out        <= '0;
            accept_w_out    <= 1'b0;
            psum_out        <= psum_in;
            psum_valid_out  <= psum_valid_in;
        end else begin
            act_out         <= act_in;
            valid_out       <= valid_in;
            switch_out      <= switch_in;
            switch_bank_out <= switch_bank_in;
            accept_w_out    <= fwd;
            weight_out      <= fwd ? weight_in : '0;
            index_out       <= fwd ? index_in  : '0;
            bank_out        <= fwd ? bank_in   : '0;
            psum_out        <= valid_in ? res : psum_in;
            psum_valid_out  <= valid_in;
            if (valid_in && ovf_now)
                ovf <= 1'b1;
            else if (clear_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: doc/pe_mb.md
PE_MB -- requirements
Module: pe_mb

Interface
REQ-001 SHALL have parameter ROW_ID, default 0, the static row index this PE matches.
REQ-002 SHALL have parameter ARRAY_WIDTH, default 16, the array size; IDX_W = $clog2(ARRAY_WIDTH).
REQ-003 SHALL have parameter DIN_W, default 8, the activation and weight width (signed).
REQ-004 SHALL have parameter ACC_W, default 32, the psum width (signed); ACC_W >= 2*DIN_W+1.
REQ-005 SHALL have parameter NUM_BANKS, default 4, the weight-bank depth (>=2); BANK_W = $clog2(NUM_BANKS).
REQ-006 SHALL have parameter SATURATE, default 0; 1 selects saturating accumulation, 0 selects wrap.
REQ-007 SHALL have ports: clk in 1, clock; rst in 1, reset (synchronous, active-high).
REQ-008 SHALL have ports: enabled in 1, column enable; clear_ovf in 1, clears the overflow flag.
REQ-009 SHALL have West ports: valid_in in 1; switch_in in 1; switch_bank_in in BANK_W; act_in in DIN_W.
REQ-010 SHALL have North ports: accept_w_in in 1; weight_in in DIN_W; index_in in IDX_W; bank_in in BANK_W; psum_in in ACC_W; psum_valid_in in 1.
REQ-011 SHALL have East ports: act_out, valid_out, switch_out and switch_bank_out, as registered copies of their West inputs.
REQ-012 SHALL have South ports: weight_out, index_out, bank_out, accept_w_out, psum_out and psum_valid_out.
REQ-013 SHALL have status ports: active_bank out BANK_W; ovf out 1 (sticky).

Function
REQ-014 SHALL register all outputs, with latency exactly 1 cycle input-to-output.
REQ-015 SHALL define match = accept_w_in && (index_in == ROW_ID).
REQ-016 SHALL, when enabled and match, write weight_in into bank[bank_in] and drive accept_w_out, weight_out, index_out and bank_out to 0 (eat).
REQ-017 SHALL, when enabled, accept_w_in=1 and no match, forward weight, index and bank south with accept_w_out=1.
REQ-018 SHALL, when enabled and accept_w_in=0, drive all south weight-path outputs to 0.
REQ-019 SHALL, when enabled and switch_in=1, set the active pointer to switch_bank_in at the clock edge.
REQ-020 SHALL compute the MAC in the switch cycle with the old pointer.
REQ-021 SHALL, on a load to the currently active bank, apply the new weight from the next cycle; the same-cycle MAC uses the old value.
REQ-022 SHALL, on a simultaneous load to bank X and switch to X, compute the first post-switch MAC with the newly loaded weight.
REQ-023 SHALL compute mac = sign-extended (act_in * bank[active]) + psum_in at ACC_W+1 bits.
REQ-024 SHALL, when enabled and valid_in=1, drive psum_out = mac result; otherwise psum_out = psum_in.
REQ-025 SHALL, when enabled, drive psum_valid_out = valid_in.
REQ-026 SHALL, with SATURATE=1, clamp the result to [-2^(ACC_W-1), 2^(ACC_W-1)-1] on overflow and set ovf.
REQ-027 SHALL, with SATURATE=0, truncate to ACC_W bits and still set ovf on signed overflow.
REQ-028 SHALL hold ovf until rst or clear_ovf; set has priority over clear in the same cycle.
REQ-029 SHALL, when enabled=0, zero the East and South weight-path outputs, and pass psum_out=psum_in and psum_valid_out=psum_valid_in.
REQ-030 SHALL, when enabled=0, clear all banks and set the active pointer to 0.
REQ-031 SHALL leave ovf unchanged while enabled=0.
REQ-032 SHALL expose the registered active pointer on active_bank.

Reset
REQ-033 SHALL, on rst, zero every output, every bank and the active pointer, and clear ovf; rst overrides enabled and all other inputs.
REQ-034 SHALL, on rst asserted mid-stream, drop any in-flight psum; the first post-reset psum_valid_out is 0.

Structure
REQ-035 SHALL place shared width constants and a pe_cfg_t struct (DIN_W, ACC_W, NUM_BANKS, SATURATE) in package pe_pkg.
REQ-036 SHALL implement the weight storage, bank write and active pointer in sub-module pe_weight_bank.
REQ-037 SHALL keep the MAC, saturation logic and datapath registers in pe_mb.

Verification
REQ-038 SHALL verify loading: ROW_ID=3; load w=5 to bank 2 with index 3; switch to bank 2; act=-4, psum=100, valid -> psum_out=80 one cycle later, psum_valid_out=1, accept_w_out=0.
REQ-039 SHALL verify forwarding: index 7 at ROW_ID=3 -> weight/index/bank forwarded south with accept_w_out=1; bank contents unchanged.
REQ-040 SHALL verify switch timing: bank0=2 and bank1=3; switch to bank1 with act=10, psum=0 in the same cycle -> psum_out=20; next cycle act=10 -> psum_out=30.
REQ-041 SHALL verify saturation: SATURATE=1, psum=0x7FFFFFF0, act=127, w=127 -> psum_out=0x7FFFFFFF, ovf=1; clear_ovf -> ovf=0.
REQ-042 SHALL verify wrap: SATURATE=0 with the same stimulus -> psum_out=0x80003EF1, ovf=1.
REQ-043 SHALL verify disable and reset: enabled=0 with psum_in=42, psum_valid_in=1 -> psum_out=42, valid_out=0, active_bank=0; rst mid-stream -> all outputs 0 the next cycle.
